// File: rtl/modulo_step_counter_pkg.sv
// Shared constants for the modulo step counter: direction and range-end policy encodings.
package modulo_step_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_step_alu.sv
// Combinational next-count computation for one enabled step, including wrap/clip decisions.
// All range arithmetic is done one bit wider than the count so limit = all-ones still works.
module counter_step_alu
    import modulo_step_counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STEP_WIDTH = 4
) (
    input  logic [WIDTH-1:0]      count,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  up_down,
    input  logic                  mode,
    output logic [WIDTH-1:0]      next_count,
    output logic                  wrap,
    output logic                  clip
);

    localparam int EW = WIDTH + 1;

    logic [EW-1:0] count_ext;
    logic [EW-1:0] step_ext;
    logic [EW-1:0] limit_ext;
    logic [EW-1:0] modulus;
    logic [EW-1:0] up_sum;
    logic          wrap_ok;

    assign count_ext = {1'b0, count};
    assign step_ext  = {{(EW-STEP_WIDTH){1'b0}}, step};
    assign limit_ext = {1'b0, limit};
    assign modulus   = limit_ext + 1'b1;
    assign up_sum    = count_ext + step_ext;

    // A step larger than the modulus cannot wrap meaningfully, so it clips instead.
    assign wrap_ok = (mode == MODE_WRAP) && (step_ext <= modulus);

    always_comb begin
        next_count = count;
        wrap       = 1'b0;
        clip       = 1'b0;
        if (count_ext > limit_ext) begin
            next_count = limit;
            clip       = 1'b1;
        end else if (up_down == DIR_UP) begin
            if (up_sum <= limit_ext) begin
                next_count = WIDTH'(up_sum);
            end else if (wrap_ok) begin
                next_count = WIDTH'(up_sum - modulus);
                wrap       = 1'b1;
            end else begin
                next_count = limit;
                clip       = 1'b1;
            end
        end else begin
            if (count_ext >= step_ext) begin
                next_count = WIDTH'(count_ext - step_ext);
            end else if (wrap_ok) begin
                next_count = WIDTH'(count_ext + modulus - step_ext);
                wrap       = 1'b1;
            end else begin
                next_count = '0;
                clip       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/modulo_step_counter.sv
// Programmable up/down counter over [0, limit_i] with runtime step, wrap or saturate ends,
// synchronous load and one-cycle wrap/clip event flags.
module modulo_step_counter
    import modulo_step_counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STEP_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      load_val_i,
    input  logic                  up_down_i,
    input  logic [STEP_WIDTH-1:0] step_i,
    input  logic [WIDTH-1:0]      limit_i,
    input  logic                  mode_i,
    output logic [WIDTH-1:0]      count_o,
    output logic                  wrap_o,
    output logic                  sat_o,
    output logic                  tc_o
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             sat_reg;
    logic             sat_next;

    logic [WIDTH-1:0] alu_count;
    logic             alu_wrap;
    logic             alu_clip;

    counter_step_alu #(
        .WIDTH      (WIDTH),
        .STEP_WIDTH (STEP_WIDTH)
    ) u_alu (
        .count      (count_reg),
        .step       (step_i),
        .limit      (limit_i),
        .up_down    (up_down_i),
        .mode       (mode_i),
        .next_count (alu_count),
        .wrap       (alu_wrap),
        .clip       (alu_clip)
    );

    // Load beats counting; a zero step is a plain hold with flags cleared.
    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        sat_next   = 1'b0;
        if (load_i) begin
            if (load_val_i > limit_i) begin
                count_next = limit_i;
                sat_next   = 1'b1;
            end else begin
                count_next = load_val_i;
            end
        end else if (en_i && (step_i != '0)) begin
            count_next = alu_count;
            wrap_next  = alu_wrap;
            sat_next   = alu_clip;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
            sat_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
            sat_reg   <= sat_next;
        end
    end

    assign count_o = count_reg;
    assign wrap_o  = wrap_reg;
    assign sat_o   = sat_reg;
    assign tc_o    = (up_down_i == DIR_DOWN) ? (count_reg == '0) : (count_reg == limit_i);

endmodule

// File: tb/tb_modulo_step_counter.sv
// Directed-vector bench: the driver queues hand-computed results, a monitor checks each cycle.
module tb_modulo_step_counter;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       en_i;
    logic       load_i;
    logic [7:0] load_val_i;
    logic       up_down_i;
    logic [3:0] step_i;
    logic [7:0] limit_i;
    logic       mode_i;
    logic [7:0] count_o;
    logic       wrap_o;
    logic       sat_o;
    logic       tc_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] count;
        logic       wrap;
        logic       sat;
        logic       tc;
    } exp_t;

    exp_t exp_q[$];

    modulo_step_counter #(.WIDTH(8), .STEP_WIDTH(4)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .en_i       (en_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .up_down_i  (up_down_i),
        .step_i     (step_i),
        .limit_i    (limit_i),
        .mode_i     (mode_i),
        .count_o    (count_o),
        .wrap_o     (wrap_o),
        .sat_o      (sat_o),
        .tc_o       (tc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Apply one cycle of inputs at the falling edge and queue the result expected after the next rising edge.
    task automatic drive(input logic en, input logic ld, input logic [7:0] lv, input logic up,
                         input logic [3:0] st, input logic [7:0] lim, input logic md,
                         input logic [7:0] e_cnt, input logic e_w, input logic e_s, input logic e_tc);
        exp_t e;
        @(negedge clk_i);
        en_i       = en;
        load_i     = ld;
        load_val_i = lv;
        up_down_i  = up;
        step_i     = st;
        limit_i    = lim;
        mode_i     = md;
        e.count    = e_cnt;
        e.wrap     = e_w;
        e.sat      = e_s;
        e.tc       = e_tc;
        exp_q.push_back(e);
        @(posedge clk_i);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                $display("txn count=%02h wrap=%0b sat=%0b tc=%0b (expect %02h %0b %0b %0b)",
                         count_o, wrap_o, sat_o, tc_o, e.count, e.wrap, e.sat, e.tc);
                chk("count", count_o, e.count);
                chk("wrap", {7'b0, wrap_o}, {7'b0, e.wrap});
                chk("sat", {7'b0, sat_o}, {7'b0, e.sat});
                chk("tc", {7'b0, tc_o}, {7'b0, e.tc});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i    = 1'b1;
        en_i       = 1'b0;
        load_i     = 1'b0;
        load_val_i = '0;
        up_down_i  = 1'b1;
        step_i     = '0;
        limit_i    = 8'hFF;
        mode_i     = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_count", count_o, 8'h00);
        chk("reset_flags", {6'b0, wrap_o, sat_o}, 8'h00);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Clamped load leaves count=0x37 with sat set, then an asynchronous reset pulse between edges.
        drive(0, 1, 8'h50, 1, 0, 8'h37, 0,  8'h37, 0, 1, 1);
        #3 reset_i = 1'b1;
        #1;
        chk("async_reset_count", count_o, 8'h00);
        chk("async_reset_flags", {6'b0, wrap_o, sat_o}, 8'h00);
        reset_i = 1'b0;

        // Wrap up, limit 9, step 3 from 8.
        drive(0, 1, 8'd8, 1, 0, 8'd9, 0,  8'd8, 0, 0, 0);
        drive(1, 0, 8'd0, 1, 3, 8'd9, 0,  8'd1, 1, 0, 0);
        drive(1, 0, 8'd0, 1, 3, 8'd9, 0,  8'd4, 0, 0, 0);
        // Wrap down, limit 9, step 3 from 1.
        drive(0, 1, 8'd1, 0, 0, 8'd9, 0,  8'd1, 0, 0, 0);
        drive(1, 0, 8'd0, 0, 3, 8'd9, 0,  8'd8, 1, 0, 0);
        drive(1, 0, 8'd0, 0, 3, 8'd9, 0,  8'd5, 0, 0, 0);
        // Saturate up at limit 200, then saturate down to 0.
        drive(0, 1, 8'd198, 1, 0, 8'd200, 1,  8'd198, 0, 0, 0);
        drive(1, 0, 8'd0,   1, 5, 8'd200, 1,  8'd200, 0, 1, 1);
        drive(1, 0, 8'd0,   1, 5, 8'd200, 1,  8'd200, 0, 1, 1);
        drive(0, 1, 8'd3,   0, 0, 8'd200, 1,  8'd3,   0, 0, 0);
        drive(1, 0, 8'd0,   0, 5, 8'd200, 1,  8'd0,   0, 1, 1);
        // Load wins over enable; clamped load flags sat, in-range load does not.
        drive(1, 1, 8'h50, 1, 5, 8'h40, 0,  8'h40, 0, 1, 1);
        drive(1, 1, 8'h20, 1, 5, 8'h40, 0,  8'h20, 0, 0, 0);
        // Full-range modulus 256, then holds via step 0 and en 0.
        drive(0, 1, 8'hFF, 1, 0, 8'hFF, 0,  8'hFF, 0, 0, 1);
        drive(1, 0, 8'h00, 1, 1, 8'hFF, 0,  8'h00, 1, 0, 0);
        drive(1, 0, 8'h00, 1, 0, 8'hFF, 0,  8'h00, 0, 0, 0);
        drive(0, 0, 8'h00, 1, 1, 8'hFF, 0,  8'h00, 0, 0, 0);
        // Count above a lowered limit clips to the limit.
        drive(0, 1, 8'h30, 1, 0, 8'hFF, 0,  8'h30, 0, 0, 0);
        drive(1, 0, 8'h00, 1, 1, 8'h10, 0,  8'h10, 0, 1, 1);
        // Wrap mode with step 5 > M=3 clips both ways.
        drive(0, 1, 8'd1, 1, 0, 8'd2, 0,  8'd1, 0, 0, 0);
        drive(1, 0, 8'd0, 1, 5, 8'd2, 0,  8'd2, 0, 1, 1);
        drive(0, 1, 8'd1, 0, 0, 8'd2, 0,  8'd1, 0, 0, 0);
        drive(1, 0, 8'd0, 0, 5, 8'd2, 0,  8'd0, 0, 1, 1);
        // Step equal to M still wraps, landing on the same value.
        drive(0, 1, 8'd2, 1, 0, 8'd2, 0,  8'd2, 0, 0, 1);
        drive(1, 0, 8'd0, 1, 3, 8'd2, 0,  8'd2, 1, 0, 1);
        drive(1, 0, 8'd0, 0, 3, 8'd2, 0,  8'd2, 1, 0, 0);

        @(negedge clk_i);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
